// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg
//   Shared definitions for the round-robin ring arbiter slice.
//   NREQ      : number of requesters on the ring
//   state_t   : arbiter FSM states (IDLE scans the ring, GRANT holds an owner)
//   SLOT_RST  : ring pointer value after reset (requester 7 is scanned first)
//   rotl1()   : one-position left rotate with bit7 -> bit0 wrap
package rr_arb_pkg;

  localparam int NREQ = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [NREQ-1:0] SLOT_RST = 8'b1000_0000;

  // Advance the one-hot ring pointer by one requester, wrapping the top bit
  // back to bit 0 so the scan never skips or repeats a slot.
  function automatic logic [NREQ-1:0] rotl1(input logic [NREQ-1:0] v);
    return {v[NREQ-2:0], v[NREQ-1]};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
//   Produces a one-cycle clock-enable pulse every DIV clk cycles. The design
//   stays on a single clock; slower activity is gated by this enable.
//   Parameters: DIV  - tick period in clk cycles (2 or more)
//   Ports:      clk  - system clock
//               rst  - synchronous active-high reset (counter back to 0)
//               tick - high for one cycle while the counter sits at DIV-1
module tick_gen
  import rr_arb_pkg::*;
#(
  parameter int DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running 0..DIV-1 counter; the tick is decoded from the terminal
  // count so it lines up with the cycle on which the counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/rr_ring_arbiter.sv
// rr_ring_arbiter
//   Eight-way round-robin arbiter driven by a slow slot tick. A one-hot ring
//   pointer (slot) advances one requester per tick while idle; when the slot
//   it points at is requesting, that requester is granted until it pulses
//   done or drops its request, after which the scan resumes at the next slot.
//   Optional macro ARB_TIMEOUT_EN bounds each grant to MAX_HOLD ticks and
//   pulses timeout on a forced revoke; without it grants are unbounded.
//   Parameters: DIV      - slot-tick period in clk cycles (2 or more)
//               MAX_HOLD - grant limit in ticks (ARB_TIMEOUT_EN builds only)
//   Ports:      clk      - system clock
//               rst      - synchronous active-high reset
//               req      - request lines, one per requester
//               done     - single-cycle release pulse from the owner
//               grant    - one-hot grant, 0 when nobody owns the resource
//               slot     - one-hot ring pointer (current scan position)
//               busy     - high while a grant is held
//               timeout  - single-cycle pulse when a grant is revoked
module rr_ring_arbiter
  import rr_arb_pkg::*;
#(
  parameter int DIV      = 1000000,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] slot,
  output logic            busy,
  output logic            timeout
);

  state_t state;
  logic   tick;
  logic   release_now;
  logic   expire;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // The owner gives up the grant either explicitly or by withdrawing its
  // request; other requesters' lines are deliberately not looked at here.
  assign release_now = done || ((req & grant) == '0);

  assign busy = (state == GRANT);

`ifdef ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_cnt;

  // Counts ticks spent in GRANT. It is cleared whenever the arbiter is idle,
  // so each new grant starts from zero without an explicit clear on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state != GRANT) begin
      hold_cnt <= '0;
    end else if (tick) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // The tick that would bring the count to MAX_HOLD ends the grant.
  assign expire = (state == GRANT) && tick && (hold_cnt == HOLD_LAST);
`else
  // Grants are unbounded; MAX_HOLD has no effect in this build.
  assign expire = 1'b0 & (MAX_HOLD > 0);
`endif

  // Main arbiter FSM. In IDLE each tick either grants the requester under
  // the pointer (pointer holds so grant == slot) or moves the pointer on.
  // Any release rotates the pointer so the previous owner goes to the back
  // of the ring. A normal release outranks a simultaneous expiry, so timeout
  // only fires when the grant is genuinely taken away.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      slot    <= SLOT_RST;
      grant   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            if ((req & slot) != '0) begin
              state <= GRANT;
              grant <= slot;
            end else begin
              slot <= rotl1(slot);
            end
          end
        end
        GRANT: begin
          if (release_now || expire) begin
            state   <= IDLE;
            grant   <= '0;
            slot    <= rotl1(slot);
            timeout <= expire && !release_now;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// tb_rr_ring_arbiter
//   Directed bench for rr_ring_arbiter with DIV=4 and MAX_HOLD=3. Each task
//   covers one behaviour and checks outputs one time unit after a rising
//   edge. Inputs change at the same point, so they take effect on the next
//   edge. After reset is released, slot ticks fall on edges 4, 8, 12, ...
module tb_rr_ring_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [7:0] slot;
  logic       busy;
  logic       timeout;

  int errors;
  int checks;

  rr_ring_arbiter #(
    .DIV     (4),
    .MAX_HOLD(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .grant  (grant),
    .slot   (slot),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle just past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges; the next edge after this returns is edge 1.
  task automatic do_reset(input logic [7:0] r);
    req  = r;
    done = 1'b0;
    rst  = 1'b1;
    step(2);
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(8'h00);
    checks++;
    if (slot !== 8'h80) begin
      errors++;
      $display("[TB] FAIL reset_slot: got %h expected %h", slot, 8'h80);
    end
    checks++;
    if (grant !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got grant=%h busy=%b timeout=%b expected 00/0/0",
               grant, busy, timeout);
    end
  endtask

  // With no requests the pointer walks one slot per tick and wraps cleanly.
  task automatic test_scan();
    logic [7:0] exp_seq [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    logic [7:0] prev;
    do_reset(8'h00);
    prev = 8'h80;
    for (int k = 0; k < 10; k++) begin
      step(3);
      checks++;
      if (slot !== prev) begin
        errors++;
        $display("[TB] FAIL scan_hold[%0d]: got %h expected %h", k, slot, prev);
      end
      step(1);
      checks++;
      if (slot !== exp_seq[k] || grant !== 8'h00) begin
        errors++;
        $display("[TB] FAIL scan_step[%0d]: got slot=%h grant=%h expected %h/00",
                 k, slot, grant, exp_seq[k]);
      end
      prev = exp_seq[k];
    end
  endtask

  // Requester 7 is served on the first tick; done releases after one cycle.
  task automatic test_grant();
    do_reset(8'h80);
    step(3);
    checks++;
    if (grant !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL grant_before_tick: got %h/%b expected 00/0", grant, busy);
    end
    step(1);
    checks++;
    if (grant !== 8'h80 || busy !== 1'b1 || slot !== 8'h80) begin
      errors++;
      $display("[TB] FAIL grant_first: got grant=%h busy=%b slot=%h expected 80/1/80",
               grant, busy, slot);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    checks++;
    if (grant !== 8'h00 || slot !== 8'h01 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL grant_done: got grant=%h slot=%h busy=%b expected 00/01/0",
               grant, slot, busy);
    end
    // done while idle must not disturb anything
    req  = 8'h00;
    done = 1'b1;
    step(1);
    done = 1'b0;
    checks++;
    if (grant !== 8'h00 || slot !== 8'h01) begin
      errors++;
      $display("[TB] FAIL done_in_idle: got grant=%h slot=%h expected 00/01", grant, slot);
    end
  endtask

  // Two requesters: 7 then 0, and 7 waits for the ring to come back around.
  task automatic test_round_robin();
    do_reset(8'h81);
    step(4);
    done = 1'b1;
    step(1);
    done = 1'b0;
    step(2);
    checks++;
    if (grant !== 8'h00 || slot !== 8'h01) begin
      errors++;
      $display("[TB] FAIL rr_wait: got grant=%h slot=%h expected 00/01", grant, slot);
    end
    step(1);
    checks++;
    if (grant !== 8'h01) begin
      errors++;
      $display("[TB] FAIL rr_next_owner: got %h expected %h", grant, 8'h01);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    checks++;
    if (grant !== 8'h00 || slot !== 8'h02) begin
      errors++;
      $display("[TB] FAIL rr_release0: got grant=%h slot=%h expected 00/02", grant, slot);
    end
    for (int i = 0; i < 26; i++) begin
      step(1);
      checks++;
      if (grant !== 8'h00) begin
        errors++;
        $display("[TB] FAIL rr_no_regrant[%0d]: got %h expected 00", i, grant);
      end
    end
    step(1);
    checks++;
    if (grant !== 8'h80 || slot !== 8'h80) begin
      errors++;
      $display("[TB] FAIL rr_wrap_regrant: got grant=%h slot=%h expected 80/80", grant, slot);
    end
  endtask

  // Other req bits are ignored during a grant; dropping the owner's bit releases.
  task automatic test_req_drop();
    logic [7:0] others [3] = '{8'hFF, 8'h80, 8'hC3};
    do_reset(8'h80);
    step(4);
    for (int i = 0; i < 3; i++) begin
      req = others[i];
      step(1);
      checks++;
      if (grant !== 8'h80) begin
        errors++;
        $display("[TB] FAIL drop_others[%0d]: got %h expected 80", i, grant);
      end
    end
    req = 8'h7F;
    step(1);
    checks++;
    if (grant !== 8'h00 || slot !== 8'h01 || busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_owner: got grant=%h slot=%h busy=%b timeout=%b expected 00/01/0/0",
               grant, slot, busy, timeout);
    end
  endtask

  // Grant bound: third tick in GRANT revokes unless done arrives on it.
  task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
    do_reset(8'h80);
    step(15);
    checks++;
    if (grant !== 8'h80 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_before: got grant=%h timeout=%b expected 80/0", grant, timeout);
    end
    step(1);
    checks++;
    if (grant !== 8'h00 || timeout !== 1'b1 || slot !== 8'h01) begin
      errors++;
      $display("[TB] FAIL to_revoke: got grant=%h timeout=%b slot=%h expected 00/1/01",
               grant, timeout, slot);
    end
    step(1);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_pulse_width: got %b expected 0", timeout);
    end
    do_reset(8'h80);
    step(15);
    done = 1'b1;
    step(1);
    done = 1'b0;
    checks++;
    if (grant !== 8'h00 || timeout !== 1'b0 || slot !== 8'h01) begin
      errors++;
      $display("[TB] FAIL to_done_wins: got grant=%h timeout=%b slot=%h expected 00/0/01",
               grant, timeout, slot);
    end
`else
    do_reset(8'h80);
    step(16);
    checks++;
    if (grant !== 8'h80 || timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unbounded_hold: got grant=%h timeout=%b busy=%b expected 80/0/1",
               grant, timeout, busy);
    end
    step(20);
    checks++;
    if (grant !== 8'h80 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unbounded_long: got grant=%h timeout=%b expected 80/0", grant, timeout);
    end
`endif
  endtask

  // Reset during a grant drops it on the next edge with no timeout pulse.
  task automatic test_reset_mid_grant();
    do_reset(8'h80);
    step(6);
    checks++;
    if (grant !== 8'h80) begin
      errors++;
      $display("[TB] FAIL mid_setup: got %h expected 80", grant);
    end
    rst = 1'b1;
    step(1);
    checks++;
    if (grant !== 8'h00 || slot !== 8'h80 || timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got grant=%h slot=%h timeout=%b busy=%b expected 00/80/0/0",
               grant, slot, timeout, busy);
    end
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    req    = 8'h00;
    done   = 1'b0;
    test_reset();
    test_scan();
    test_grant();
    test_round_robin();
    test_req_drop();
    test_timeout();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_ring_arbiter.md
RR_RING_ARBITER -- requirements
Module: rr_ring_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset (`rst`); all state SHALL update on the rising edge of `clk` only, with no derived clocks.
REQ-002 Parameter DIV, default 1000000, SHALL set the slot-tick period in clk cycles (legal range 2 and above).
REQ-003 Parameter MAX_HOLD, default 16, SHALL set the maximum grant length in ticks (used only with ARB_TIMEOUT_EN; legal range 1 and above).
REQ-004 Port `clk`, input, width 1: system clock.
REQ-005 Port `rst`, input, width 1: synchronous active-high reset.
REQ-006 Port `req`, input, width 8: request lines, one per requester.
REQ-007 Port `done`, input, width 1: single-cycle release pulse from the current owner.
REQ-008 Port `grant`, output reg, width 8: one-hot grant, or 0 when no requester is granted.
REQ-009 Port `slot`, output reg, width 8: one-hot ring pointer (the current scan position).
REQ-010 Port `busy`, output, width 1: high while in the GRANT state.
REQ-011 Port `timeout`, output reg, width 1: single-cycle pulse on a forced revoke.

Function
REQ-012 The tick generator SHALL pulse an internal `tick` for 1 cycle every DIV cycles: the counter runs 0..DIV-1 and `tick` asserts when the counter equals DIV-1, then the counter wraps to 0.
REQ-013 The FSM SHALL have two states, IDLE and GRANT, and SHALL come out of reset in IDLE.
REQ-014 In IDLE, on a tick where (req & slot) is nonzero, the FSM SHALL move to GRANT and set grant to slot on the next edge; `slot` SHALL hold.
REQ-015 In IDLE, on a tick where (req & slot) is zero, `slot` SHALL rotate left by 1 with wrap (bit7 goes to bit0); this is a 1-position-per-tick scan.
REQ-016 In IDLE with no tick, `slot` and `grant` SHALL hold.
REQ-017 In GRANT, `done`=1 or `req` bit for the granted requester =0 SHALL cause, on the next edge: grant=0, slot rotated left by 1, and state IDLE.
REQ-018 Changes on `req` bits other than the granted one SHALL be ignored during GRANT.
REQ-019 `done` SHALL be ignored in IDLE.
REQ-020 Requester 7 SHALL be the first served after reset; wrap from bit7 to bit0 SHALL be seamless, so no slot is skipped or repeated.
REQ-021 Latency from the qualifying tick to grant SHALL be 1 cycle, and latency from `done` to grant=0 SHALL be 1 cycle.
REQ-022 `grant` SHALL always be zero or one-hot, and SHALL equal `slot` whenever it is nonzero.

Reset
REQ-023 While `rst` is high, on each edge the block SHALL set: slot=8'b1000_0000, grant=0, state=IDLE, tick counter=0, hold counter=0, timeout=0.
REQ-024 A reset asserted mid-grant SHALL drop `grant` on the next edge without producing a `timeout` pulse.

Configuration
REQ-025 With macro ARB_TIMEOUT_EN defined, the block SHALL count ticks while in GRANT.
REQ-026 With ARB_TIMEOUT_EN defined, when the count reaches MAX_HOLD the block SHALL force the release behaviour of REQ-017 and pulse `timeout` for 1 cycle.
REQ-027 With ARB_TIMEOUT_EN defined, a `done` in the same cycle as the MAX_HOLD tick SHALL win: a normal release occurs and `timeout` stays 0.
REQ-028 Without ARB_TIMEOUT_EN, there SHALL be no hold counter, grants SHALL be unbounded, and `timeout` SHALL be tied to 0.

Structure
REQ-029 Shared package rr_arb_pkg SHALL hold: NREQ=8, the state enum {IDLE, GRANT}, and the slot reset constant 8'b1000_0000.
REQ-030 A sub-module named tick_gen (parameter DIV; ports clk, rst, tick) SHALL produce the clock-enable tick in place of a divided clock.

Verification
REQ-031 Scenario (DIV=4): reset, then req=0 for 40 cycles -> slot walks 80,01,02,...,80 one step per 4 cycles; grant=0 throughout.
REQ-032 Scenario: req=8'h80 from reset -> grant=8'h80 and busy=1 one cycle after the first tick; done pulse -> grant=0 next cycle and slot=8'h01.
REQ-033 Scenario: req=8'h81, with owner 80 releasing -> grant=8'h01 on the very next tick; requester 7 is not re-granted until slot wraps back to 8'h80.
REQ-034 Scenario: granted requester drops its req bit without `done` -> grant=0 next cycle; toggling other req bits during GRANT -> no change to grant.
REQ-035 Scenario (ARB_TIMEOUT_EN, MAX_HOLD=3): hold req, never pulse done -> grant drops and timeout=1 for exactly 1 cycle after the 3rd tick; done on that same tick -> timeout stays 0.
REQ-036 Scenario: assert rst mid-grant -> next edge gives grant=0, slot=8'h80, timeout=0.
